// File: rtl/mux4x1_rr_sel.sv
// Round-robin select generator for a 4:1 mux.
// Grants one requester at a time for bursts of up to MAX_BURST beats.
module mux4x1_rr_sel #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid,
    output logic       last
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    ptr;
    logic [1:0]    ptr_nx;
    logic [1:0]    sel_nx;
    logic [3:0]    grant_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [3:0]    req_m;

    logic busy;
    logic req_sel;
    logic beat;
    logic at_last;
    logic drop;
    logic rel;

    // First requester at or after p, wrapping around the four sources.
    function automatic logic [1:0] arb(
        input logic [1:0] p,
        input logic [3:0] r
    );
        logic [1:0] idx;
        arb = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) arb = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        onehot = 4'b0001 << s;
    endfunction

    // State, pointer, select, grant and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            grant <= 4'b0000;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
            grant <= grant_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: start a grant from IDLE, count beats, rotate on release.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        grant_nx = grant;
        cnt_nx   = cnt;
        req_m    = req;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    sel_nx   = arb(ptr, req);
                    grant_nx = onehot(sel_nx);
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_nx = sel + 2'd1;
                    // A source that dropped its request is not re-granted.
                    if (drop) req_m = req & ~onehot(sel);
                    cnt_nx = '0;
                    if (|req_m) begin
                        sel_nx   = arb(ptr_nx, req_m);
                        grant_nx = onehot(sel_nx);
                    end else begin
                        grant_nx = 4'b0000;
                        state_nx = IDLE;
                    end
                end else if (beat) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
        endcase
    end

    // Beat handshake outputs and release conditions.
    always_comb begin
        busy    = (state == BUSY);
        req_sel = req[sel];
        valid   = busy & req_sel;
        at_last = (cnt == LAST_CNT);
        last    = valid & at_last;
        beat    = valid & ready;
        drop    = busy & ~req_sel;
        rel     = (beat & last) | drop;
    end

endmodule

// File: tb/tb_mux4x1_rr_sel.sv
// Bench for mux4x1_rr_sel: directed scenarios plus randomized traffic
// compared every cycle against a behavioural arbitration model.
module tb_mux4x1_rr_sel;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       last;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    // behavioural model state
    bit m_busy = 0;
    int m_sel  = 0;
    int m_ptr  = 0;
    int m_beats = 0;

    mux4x1_rr_sel #(.MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .sel   (sel),
        .grant (grant),
        .valid (valid),
        .last  (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int marb(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    // model: advance one clock using the inputs seen at this edge
    always @(posedge clk) begin
        bit          v;
        logic [3:0]  r2;
        if (rst) begin
            m_busy  = 0;
            m_ptr   = 0;
            m_sel   = 0;
            m_beats = 0;
        end else if (!m_busy) begin
            if (req != 4'b0) begin
                m_sel   = marb(m_ptr, req);
                m_busy  = 1;
                m_beats = 0;
            end
        end else begin
            v = req[m_sel];
            if (!v || (ready && m_beats == MB - 1)) begin
                m_ptr = (m_sel + 1) % 4;
                r2 = req;
                if (!v) r2[m_sel] = 1'b0;
                m_beats = 0;
                if (r2 != 4'b0) m_sel = marb(m_ptr, r2);
                else m_busy = 0;
            end else if (ready) begin
                m_beats++;
            end
        end
    end

    // compare DUT against the model away from the active edge
    always @(negedge clk) begin
        bit e_v;
        if (check_en) begin
            e_v = m_busy && req[m_sel];
            chk("m_sel", 32'(sel), 32'(m_sel));
            chk("m_grant", 32'(grant),
                m_busy ? 32'(4'b0001 << m_sel) : 32'd0);
            chk("m_valid", 32'(valid), 32'(e_v));
            chk("m_last", 32'(last), 32'(e_v && m_beats == MB - 1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int beats;
        bit done;

        // 1. reset with all requests high
        rst   = 1'b1;
        req   = 4'b1111;
        ready = 1'b1;
        cyc();
        check_en = 1;
        cyc();
        @(negedge clk);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_last", 32'(last), 0);
        cyc();

        // 2. single source, re-grant without bubble
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        chk("one_idle_valid", 32'(valid), 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("one_grant", 32'(grant), 32'h4);
            chk("one_sel", 32'(sel), 2);
            chk("one_valid", 32'(valid), 1);
            chk("one_last", 32'(last), 32'(i == 3));
            cyc();
        end
        @(negedge clk);
        chk("one_regrant", 32'(grant), 32'h4);
        chk("one_regrant_valid", 32'(valid), 1);
        chk("one_regrant_last", 32'(last), 0);
        cyc();

        // 3. rotation over all four sources
        do_reset();
        req = 4'b1111;
        cyc();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("rot_sel", 32'(sel), 32'((k / 4) % 4));
            chk("rot_last", 32'(last), 32'(k % 4 == 3));
            cyc();
        end

        // 4. backpressure mid-burst
        do_reset();
        req = 4'b0001;
        cyc();
        @(negedge clk);
        chk("bp_first", 32'(valid), 1);
        cyc();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_sel", 32'(sel), 0);
            chk("bp_hold_valid", 32'(valid), 1);
            chk("bp_hold_last", 32'(last), 0);
            cyc();
        end
        ready = 1'b1;
        beats = 1;
        done  = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (valid && ready) beats++;
            done = last;
            cyc();
        end
        chk("bp_beats", 32'(beats), 4);

        // 5. request drop mid-burst
        do_reset();
        req = 4'b0010;
        cyc();
        @(negedge clk);
        chk("drop_sel1", 32'(sel), 1);
        cyc();
        cyc();
        req = 4'b1000;
        @(negedge clk);
        chk("drop_valid", 32'(valid), 0);
        cyc();
        @(negedge clk);
        chk("drop_sel", 32'(sel), 3);
        chk("drop_grant", 32'(grant), 32'h8);
        chk("drop_nvalid", 32'(valid), 1);
        cyc();

        // 6. reset in the middle of a burst
        do_reset();
        req = 4'b0100;
        cyc();
        cyc();
        rst = 1'b1;
        req = 4'b1111;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_grant", 32'(grant), 0);
        chk("mrst_sel", 32'(sel), 0);
        chk("mrst_valid", 32'(valid), 0);
        cyc();
        @(negedge clk);
        chk("mrst_arb0", 32'(grant), 32'h1);
        cyc();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
